// File: rtl/data_ram_responder.sv
// Data-memory responder for the MEM stage: serves one word access at a time
// after a fixed number of wait states, stalling the pipeline while busy.
module data_ram_responder #(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter logic [31:0] INIT_VALUE  = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        ram_en,
  input  logic [3:0]  ram_write_en,
  input  logic [31:0] ram_addr,
  input  logic [31:0] ram_write_data,
  output logic [31:0] ram_read_data,
  output logic        stall_request,
  output logic        access_done
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  state_e                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
  logic [3:0]              be_q, be_d;
  logic [31:0]             wdata_q, wdata_d;
  logic [31:0]             rdata_q, rdata_d;
  logic                    mem_we;
  logic [31:0]             mem_q [Depth];

  // Address bits outside the word index are deliberately ignored (aliasing).
  logic unused_addr;
  assign unused_addr = ^{ram_addr[31:ADDR_WIDTH+2], ram_addr[1:0]};

  // State and request-latch registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Memory array: cleared to INIT_VALUE on reset, byte-lane writes on commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= INIT_VALUE;
      end
    end else if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (be_q[b]) begin
          mem_q[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
        end
      end
    end
  end

  // Next-state logic: accept, count down wait states, then commit or abort.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    mem_we  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (ram_en && !flush) begin
          state_d = StWait;
          cnt_d   = 4'(WAIT_CYCLES);
          idx_d   = ram_addr[ADDR_WIDTH+1:2];
          be_d    = ram_write_en;
          wdata_d = ram_write_data;
        end
      end
      StWait: begin
        // Flush wins even on the commit cycle.
        if (flush) begin
          state_d = StIdle;
        end else if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = StDone;
          if (be_q != 4'b0000) begin
            mem_we = 1'b1;
          end else begin
            rdata_d = mem_q[idx_q];
          end
        end
      end
      StDone: begin
        // ram_en here is the same request still in MEM; never re-issue it.
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs: stall is combinational on acceptance so the request holds.
  always_comb begin
    stall_request = 1'b0;
    access_done   = 1'b0;
    unique case (state_q)
      StIdle:  stall_request = ram_en && !flush;
      StWait:  stall_request = 1'b1;
      StDone:  access_done   = 1'b1;
      default: stall_request = 1'b0;
    endcase
  end

  assign ram_read_data = rdata_q;

endmodule

// File: tb/tb_data_ram_responder.sv
// Directed self-checking bench for data_ram_responder (WAIT_CYCLES = 1).
module tb_data_ram_responder;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        ram_en;
  logic [3:0]  ram_write_en;
  logic [31:0] ram_addr;
  logic [31:0] ram_write_data;
  logic [31:0] ram_read_data;
  logic        stall_request;
  logic        access_done;

  int n_checks = 0;
  int n_errors = 0;

  data_ram_responder #(
    .ADDR_WIDTH (10),
    .WAIT_CYCLES(1),
    .INIT_VALUE (32'h0)
  ) u_dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .ram_en        (ram_en),
    .ram_write_en  (ram_write_en),
    .ram_addr      (ram_addr),
    .ram_write_data(ram_write_data),
    .ram_read_data (ram_read_data),
    .stall_request (stall_request),
    .access_done   (access_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one access at a negedge, hold it until access_done, return the
  // number of stalled cycles and the read data seen in the DONE cycle.
  task automatic do_access(input logic [3:0] we, input logic [31:0] addr,
                           input logic [31:0] data, input bit hold,
                           output int stalls, output logic [31:0] rd);
    bit seen;
    seen   = 1'b0;
    stalls = 0;
    rd     = '0;
    ram_en = 1'b1;
    ram_write_en = we;
    ram_addr = addr;
    ram_write_data = data;
    for (int c = 0; c < 40 && !seen; c++) begin
      #1;
      if (stall_request) stalls++;
      if (access_done) begin
        seen = 1'b1;
        rd   = ram_read_data;
      end else begin
        @(negedge clk);
      end
    end
    chk("done_seen", 32'(seen), 32'd1);
    if (!hold) begin
      ram_en = 1'b0;
      ram_write_en = 4'b0000;
    end
    @(negedge clk);
  endtask

  int          st;
  logic [31:0] rd;

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    ram_en = 1'b0;
    ram_write_en = 4'b0000;
    ram_addr = '0;
    ram_write_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_stall", 32'(stall_request), 32'd0);
    chk("rst_done", 32'(access_done), 32'd0);
    chk("rst_rdata", ram_read_data, 32'h0);
    @(negedge clk);

    // Read after reset: 3 stall cycles, data = INIT_VALUE.
    do_access(4'b0000, 32'h40, 32'h0, 1'b0, st, rd);
    chk("rd40_stalls", 32'(st), 32'd3);
    chk("rd40_data", rd, 32'h0);

    // Full write then read; writes leave ram_read_data alone.
    do_access(4'b1111, 32'h100, 32'hDEADBEEF, 1'b0, st, rd);
    chk("wr100_stalls", 32'(st), 32'd3);
    chk("wr100_rdata_held", rd, 32'h0);
    do_access(4'b0000, 32'h100, 32'h0, 1'b0, st, rd);
    chk("rd100_data", rd, 32'hDEADBEEF);

    // Byte lanes.
    do_access(4'b1111, 32'h180, 32'h11223344, 1'b0, st, rd);
    do_access(4'b0100, 32'h180, 32'h00AA0000, 1'b0, st, rd);
    do_access(4'b0000, 32'h180, 32'h0, 1'b0, st, rd);
    chk("lane_0100", rd, 32'h11AA3344);
    do_access(4'b0011, 32'h180, 32'h00005566, 1'b0, st, rd);
    do_access(4'b0000, 32'h180, 32'h0, 1'b0, st, rd);
    chk("lane_0011", rd, 32'h11AA5566);

    // Flush in the first WAIT cycle of a write.
    do_access(4'b1111, 32'h200, 32'h12345678, 1'b0, st, rd);
    ram_en = 1'b1; ram_write_en = 4'b1111; ram_addr = 32'h200; ram_write_data = 32'hCAFEF00D;
    #1;
    chk("fl_accept_stall", 32'(stall_request), 32'd1);
    @(negedge clk);
    flush = 1'b1;
    #1;
    chk("fl_wait_stall", 32'(stall_request), 32'd1);
    chk("fl_wait_done", 32'(access_done), 32'd0);
    @(negedge clk);
    flush = 1'b0; ram_en = 1'b0; ram_write_en = 4'b0000;
    #1;
    chk("fl_after_stall", 32'(stall_request), 32'd0);
    chk("fl_after_done", 32'(access_done), 32'd0);
    @(negedge clk);
    #1;
    chk("fl_after2_done", 32'(access_done), 32'd0);
    @(negedge clk);
    do_access(4'b0000, 32'h200, 32'h0, 1'b0, st, rd);
    chk("fl_word_kept", rd, 32'h12345678);

    // Flush on the cycle the counter hits zero: aborted read keeps old data.
    ram_en = 1'b1; ram_write_en = 4'b0000; ram_addr = 32'h100;
    @(negedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; ram_en = 1'b0;
    #1;
    chk("fl0_stall", 32'(stall_request), 32'd0);
    chk("fl0_done", 32'(access_done), 32'd0);
    chk("fl0_rdata", ram_read_data, 32'h12345678);
    @(negedge clk);

    // ram_en held through DONE: one pulse, then a fresh acceptance.
    do_access(4'b0000, 32'h180, 32'h0, 1'b1, st, rd);
    chk("hold_data", rd, 32'h11AA5566);
    #1;
    chk("hold_idle_done", 32'(access_done), 32'd0);
    chk("hold_idle_stall", 32'(stall_request), 32'd1);
    do_access(4'b0000, 32'h100, 32'h0, 1'b0, st, rd);
    chk("b2b_stalls", 32'(st), 32'd3);
    chk("b2b_data", rd, 32'hDEADBEEF);

    // Aliasing modulo 1024 words.
    do_access(4'b1111, 32'h1000, 32'hA5A50F0F, 1'b0, st, rd);
    do_access(4'b0000, 32'h0000, 32'h0, 1'b0, st, rd);
    chk("alias_data", rd, 32'hA5A50F0F);

    // Reset during WAIT of a write.
    do_access(4'b1111, 32'h300, 32'h77777777, 1'b0, st, rd);
    ram_en = 1'b1; ram_write_en = 4'b1111; ram_addr = 32'h300; ram_write_data = 32'h88888888;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; ram_en = 1'b0; ram_write_en = 4'b0000;
    #1;
    chk("rstmid_stall", 32'(stall_request), 32'd0);
    chk("rstmid_done", 32'(access_done), 32'd0);
    chk("rstmid_rdata", ram_read_data, 32'h0);
    @(negedge clk);
    do_access(4'b0000, 32'h300, 32'h0, 1'b0, st, rd);
    chk("rstmid_word", rd, 32'h0);
    do_access(4'b0000, 32'h100, 32'h0, 1'b0, st, rd);
    chk("rstmid_other", rd, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
